// File: rtl/fetch_sequencer_pkg.sv
// Shared constants and state encoding for the instruction-fetch sequencer.
package fetch_sequencer_pkg;

    localparam int unsigned DEF_ADDR_SIZE = 32;
    localparam int unsigned DEF_WORD_LEN  = 32;
    localparam logic [31:0] DEF_RESET_PC  = 32'h8000_0000;

    // FETCH: idle, WAIT: response wanted, DRAIN: response stale
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/response port plus the decode-side valid/ready output.
interface fetch_sequencer_if
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int unsigned WORD_LEN  = DEF_WORD_LEN
);
    logic                 imem_req_valid;
    logic [ADDR_SIZE-1:0] imem_req_addr;
    logic                 imem_req_ready;
    logic                 imem_rsp_valid;
    logic [WORD_LEN-1:0]  imem_rsp_data;
    logic                 inst_valid;
    logic [WORD_LEN-1:0]  inst_data;
    logic [ADDR_SIZE-1:0] inst_pc;
    logic                 inst_ready;

    // Fetch side: issues requests, presents instructions
    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output inst_valid, inst_data, inst_pc,
        input  inst_ready
    );

    // Environment side: memory and decode
    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  inst_valid, inst_data, inst_pc,
        output inst_ready
    );

endinterface

// File: rtl/fetch_sequencer_out_buf.sv
// One-entry valid/ready output register holding a fetched instruction and its PC.
module fetch_out_buf
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int unsigned WORD_LEN  = DEF_WORD_LEN
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 load,
    input  logic [WORD_LEN-1:0]  load_data,
    input  logic [ADDR_SIZE-1:0] load_pc,
    input  logic                 ready,
    output logic                 valid,
    output logic [WORD_LEN-1:0]  data,
    output logic [ADDR_SIZE-1:0] pc
);

    // Clear beats load, load beats consumption
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            data  <= '0;
            pc    <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            pc    <= load_pc;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, issues one fetch at a time,
// applies redirects and drops responses made stale by them.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned          ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int unsigned          WORD_LEN  = DEF_WORD_LEN,
    parameter logic [ADDR_SIZE-1:0] RESET_PC  = DEF_RESET_PC
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 stall_i,
    input  logic                 redirect_valid,
    input  logic [ADDR_SIZE-1:0] redirect_target,
    output logic                 flush_o,
    fetch_sequencer_if.master    bus
);

    localparam logic [ADDR_SIZE-1:0] ALIGN_MASK = {{(ADDR_SIZE-2){1'b1}}, 2'b00};

    fetch_state_t         state;
    logic [ADDR_SIZE-1:0] pc;
    logic [ADDR_SIZE-1:0] req_pc;
    logic                 issue;
    logic                 capture;

    // Issue only when idle, unblocked, and the output slot is free or draining;
    // gated by reset so no request shows while reset is held.
    always_comb begin
        issue   = reset_n && (state == S_FETCH) && !stall_i && !redirect_valid
                  && (!bus.inst_valid || bus.inst_ready);
        capture = (state == S_WAIT) && bus.imem_rsp_valid && !redirect_valid;
    end

    assign bus.imem_req_valid = issue;
    assign bus.imem_req_addr  = pc;

    // Fetch FSM, PC and flush pulse; redirect takes priority in every state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_FETCH;
            pc      <= RESET_PC;
            req_pc  <= RESET_PC;
            flush_o <= 1'b0;
        end else begin
            flush_o <= redirect_valid;
            if (redirect_valid) begin
                pc <= redirect_target & ALIGN_MASK;
                // An outstanding fetch without its response yet must be drained
                unique case (state)
                    S_WAIT, S_DRAIN: state <= bus.imem_rsp_valid ? S_FETCH : S_DRAIN;
                    default:         state <= S_FETCH;
                endcase
            end else begin
                unique case (state)
                    S_FETCH: begin
                        if (issue && bus.imem_req_ready) begin
                            req_pc <= pc;
                            pc     <= pc + ADDR_SIZE'(4);
                            state  <= S_WAIT;
                        end
                    end
                    S_WAIT, S_DRAIN: begin
                        if (bus.imem_rsp_valid) state <= S_FETCH;
                    end
                    default: state <= S_FETCH;
                endcase
            end
        end
    end

    fetch_out_buf #(
        .ADDR_SIZE (ADDR_SIZE),
        .WORD_LEN  (WORD_LEN)
    ) u_out_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (redirect_valid),
        .load      (capture),
        .load_data (bus.imem_rsp_data),
        .load_pc   (req_pc),
        .ready     (bus.inst_ready),
        .valid     (bus.inst_valid),
        .data      (bus.inst_data),
        .pc        (bus.inst_pc)
    );

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller that owns the program counter and sequences it against a request/response instruction-memory port. It issues one fetch at a time and advances the PC by 4. It applies branch/jump redirects from the execute stage, discards responses made stale by a redirect, and presents fetched instructions to decode through a one-entry valid/ready output register.

## Interface
- `ADDR_SIZE`, 32: fetch address width; equal to `` `ADDR_SIZE`` from `defines.v`.
- `WORD_LEN`, 32: instruction width; equal to `` `WORD_LEN`` from `defines.v`.
- `RESET_PC`, 32'h80000000: PC value loaded on reset.
- `clk` in 1: single clock; all state updates on posedge.
- `reset_n` in 1: reset is asynchronous and active-low.
- `stall_i` in 1: hazard hold; blocks issue of new fetches only.
- `redirect_valid` in 1: taken branch/jump this cycle (branch-control output).
- `redirect_target` in ADDR_SIZE: redirect address; bits [1:0] are ignored and forced to 0.
- `imem_req_valid` out 1: fetch request.
- `imem_req_addr` out ADDR_SIZE: fetch address; equals the internal PC.
- `imem_req_ready` in 1: memory accepts the request.
- `imem_rsp_valid` in 1: response data valid; at most one per accepted request, never in the same cycle as its request.
- `imem_rsp_data` in WORD_LEN: fetched instruction.
- `inst_valid` out 1: output register holds an instruction.
- `inst_data` out WORD_LEN: buffered instruction.
- `inst_pc` out ADDR_SIZE: address of `inst_data`.
- `inst_ready` in 1: decode consumes the instruction.
- `flush_o` out 1: registered one-cycle pulse after a redirect is taken.

## Operation
- **Registers:** `pc`, `req_pc` (address of the outstanding fetch), output register {`inst_valid`, `inst_data`, `inst_pc`}, `flush_o`, and a 2-bit state.
- **States:**
  - FETCH: no request outstanding.
  - WAIT: one request outstanding; the response is wanted.
  - DRAIN: one request outstanding; the response is stale.
- **Issue condition:** `imem_req_valid` = state==FETCH && !`stall_i` && !`redirect_valid` && (!`inst_valid` || `inst_ready`). This is combinational.
- **FETCH:** when `imem_req_valid` && `imem_req_ready`: `req_pc`<=`pc`, `pc`<=`pc`+4 (mod 2^ADDR_SIZE wrap), go to WAIT.
- **WAIT, on `imem_rsp_valid`:** load the output register with {1, `imem_rsp_data`, `req_pc`}, go to FETCH.
- **Redirect (highest priority, any state):**
  - `pc`<=`redirect_target`&~3; `inst_valid`<=0 even if `inst_ready` is high; `flush_o`<=1 next cycle.
  - In FETCH: stay in FETCH; no request is issued that cycle.
  - In WAIT without `imem_rsp_valid`: go to DRAIN.
  - In WAIT or DRAIN with `imem_rsp_valid` in the same cycle: the response is discarded; go to FETCH.
- **DRAIN:** on `imem_rsp_valid`, discard and go to FETCH. A further redirect in DRAIN updates `pc` and stays in DRAIN.
- **Output handshake:** `inst_valid` && `inst_ready` clears `inst_valid` unless a new response loads the register in the same cycle.
- **Stall:** `stall_i` never blocks response capture or redirect. The output register is never overwritten while valid and not consumed; the issue condition guarantees this.

## Timing
- **Reset values (while `reset_n`=0):** `pc`=RESET_PC, `req_pc`=RESET_PC, state=FETCH, `inst_valid`=0, `inst_data`=0, `inst_pc`=0, `flush_o`=0. `imem_req_valid`=0 during reset.
- **First cycle after reset release:** `imem_req_valid`=1 with `imem_req_addr`=RESET_PC, provided `stall_i`=0.
- **Fetch latency:** request accepted at edge N, response at cycle N+k (k≥1), `inst_valid` high from edge N+k+1.
- **Throughput:** best-case one instruction per 2 cycles (memory with k=1, `inst_ready` tied high).
- **Redirect:** `redirect_valid` at cycle R gives `imem_req_addr`=target from R+1 (if no drain is needed), and `flush_o`=1 for exactly cycle R+1.
- **Mid-operation reset:** reset abandons any outstanding request. Memory must drop it too; a response arriving after release in FETCH is ignored.

## Structure
- `RESET_PC` default and state encodings (FETCH=2'd0, WAIT=2'd1, DRAIN=2'd2) belong in `defines.v` alongside `` `WORD_LEN``/`` `ADDR_SIZE``.
- One natural sub-module: `fetch_out_buf`, the one-entry valid/ready output register with a clear input. The FSM and PC stay in `fetch_sequencer`.

## Test plan
- **Reset release, memory k=1, `inst_ready`=1:** requests 0x80000000, 0x80000004, 0x80000008 on alternate cycles; `inst_pc` follows the same sequence with matching data.
- **Redirect to 0x80000103 while in WAIT:** the stale response is dropped, the next request address is 0x80000100, and `flush_o` is high for exactly one cycle.
- **Redirect in the same cycle as `imem_rsp_valid`:** no `inst_valid` for that data; state goes directly to FETCH and the next request is to the target.
- **`inst_ready`=0 for 5 cycles with `inst_valid`=1:** no further request issues and `inst_data` stays stable; after ready, fetching resumes at `inst_pc`+4.
- **`stall_i`=1 for 3 cycles while in WAIT:** the response is still captured; no new request until `stall_i`=0.
- **`reset_n` asserted during WAIT:** outputs return to reset values immediately (asynchronous); after release, fetch restarts at 0x80000000.
